// File: rtl/clk_period_monitor_mc.sv
// Multi-channel clock period / glitch monitor: measures edge-to-edge intervals of NCH async clocks in clk_ref cycles.
// Latency: clk_mon transition to internal edge 2-3 cycles; edge to period_vld/period_last/viol_cnt/fault 1 cycle.
// Backpressure: none; period_vld is a 1-cycle pulse, status outputs are sticky until clear or reset.
//
// Ports: clk_ref/rst_n (reference clock, async active-low reset); clk_mon, ch_en, clear (per channel);
// min_period/max_period (per-channel window, channel i at [i*CW +: CW]); fault, fault_any, fault_type,
// period_last, period_vld, viol_cnt (per-channel status, same packing).
module clk_period_monitor_mc #(
    parameter int NCH        = 4,
    parameter int CW         = 16,
    parameter int EDGE_MODE  = 0,
    parameter int VIOL_LIMIT = 2,
    parameter int VCW        = 8
) (
    input  logic              clk_ref,
    input  logic              rst_n,
    input  logic [NCH-1:0]    clk_mon,
    input  logic [NCH-1:0]    ch_en,
    input  logic [NCH*CW-1:0] min_period,
    input  logic [NCH*CW-1:0] max_period,
    input  logic [NCH-1:0]    clear,
    output logic [NCH-1:0]    fault,
    output logic              fault_any,
    output logic [2*NCH-1:0]  fault_type,
    output logic [NCH*CW-1:0] period_last,
    output logic [NCH-1:0]    period_vld,
    output logic [NCH*VCW-1:0] viol_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_STALL} state_t;

    localparam logic [1:0] T_FAST  = 2'b01;
    localparam logic [1:0] T_SLOW  = 2'b10;
    localparam logic [1:0] T_STALL = 2'b11;
    localparam int         CSW     = 4;
    localparam logic [CSW-1:0] LIM = CSW'(VIOL_LIMIT);

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_ch
            logic           s1, s2, hist;
            logic           edge_det;
            state_t         state_q, state_d;
            logic [CW-1:0]  cnt_q, cnt_d;
            logic [CW-1:0]  mn, mx;
            logic           viol, good, chk;
            logic [1:0]     vtype;
            logic [CSW-1:0] consec_q, consec_b, consec_n;
            logic           fault_q, fault_b, fault_n;
            logic [1:0]     type_q, type_b, type_n;
            logic [VCW-1:0] vc_q, vc_b, vc_n;
            logic [CW-1:0]  plast_q;
            logic           pvld_q;

            assign mn = min_period[g*CW +: CW];
            assign mx = max_period[g*CW +: CW];

            // Synchronizer and history flop run regardless of ch_en so the
            // edge detector is already settled when the channel is armed.
            always_ff @(posedge clk_ref or negedge rst_n) begin
                if (!rst_n) begin
                    s1   <= 1'b0;
                    s2   <= 1'b0;
                    hist <= 1'b0;
                end else begin
                    s1   <= clk_mon[g];
                    s2   <= s1;
                    hist <= s2;
                end
            end

            assign edge_det = (EDGE_MODE != 0) ? (s2 ^ hist) : (s2 & ~hist);

            // Channel FSM and interval counter. An edge takes priority over the
            // stall check, so an edge arriving exactly at cnt=max+1 is a slow
            // interval rather than a stall.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                viol    = 1'b0;
                vtype   = 2'b00;
                good    = 1'b0;
                chk     = 1'b0;
                if (!ch_en[g]) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    if (edge_det)
                        cnt_d = CW'(1);
                    else if (cnt_q != '1)
                        cnt_d = cnt_q + 1'b1;
                    case (state_q)
                        S_IDLE: begin
                            state_d = S_ARM;
                            cnt_d   = '0;
                        end
                        S_ARM: begin
                            if (edge_det) begin
                                state_d = S_RUN;
                            end else if (cnt_q > mx) begin
                                state_d = S_STALL;
                                viol    = 1'b1;
                                vtype   = T_STALL;
                            end
                        end
                        S_RUN: begin
                            if (edge_det) begin
                                chk = 1'b1;
                                if (cnt_q > mx) begin
                                    viol  = 1'b1;
                                    vtype = T_SLOW;
                                end else if (cnt_q < mn) begin
                                    viol  = 1'b1;
                                    vtype = T_FAST;
                                end else begin
                                    good = 1'b1;
                                end
                            end else if (cnt_q > mx) begin
                                state_d = S_STALL;
                                viol    = 1'b1;
                                vtype   = T_STALL;
                            end
                        end
                        S_STALL: begin
                            if (edge_det)
                                state_d = S_RUN;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end

            // Clear is folded in before the violation update, so a clear and a
            // violation in the same cycle leave a count of exactly one.
            always_comb begin
                consec_b = clear[g] ? '0    : consec_q;
                fault_b  = clear[g] ? 1'b0  : fault_q;
                type_b   = clear[g] ? 2'b00 : type_q;
                vc_b     = clear[g] ? '0    : vc_q;
                consec_n = consec_b;
                fault_n  = fault_b;
                type_n   = type_b;
                vc_n     = vc_b;
                if (viol) begin
                    if (vc_b != '1)
                        vc_n = vc_b + 1'b1;
                    if (consec_b < LIM)
                        consec_n = consec_b + 1'b1;
                    if (consec_n == LIM) begin
                        fault_n = 1'b1;
                        if (!fault_b)
                            type_n = vtype;
                    end
                end else if (good) begin
                    consec_n = '0;
                end
            end

            always_ff @(posedge clk_ref or negedge rst_n) begin
                if (!rst_n) begin
                    state_q  <= S_IDLE;
                    cnt_q    <= '0;
                    consec_q <= '0;
                    fault_q  <= 1'b0;
                    type_q   <= 2'b00;
                    vc_q     <= '0;
                    plast_q  <= '0;
                    pvld_q   <= 1'b0;
                end else begin
                    state_q  <= state_d;
                    cnt_q    <= cnt_d;
                    consec_q <= consec_n;
                    fault_q  <= fault_n;
                    type_q   <= type_n;
                    vc_q     <= vc_n;
                    pvld_q   <= chk;
                    if (chk)
                        plast_q <= cnt_q;
                end
            end

            assign fault[g]                 = fault_q;
            assign fault_type[2*g +: 2]     = type_q;
            assign period_last[g*CW +: CW]  = plast_q;
            assign period_vld[g]            = pvld_q;
            assign viol_cnt[g*VCW +: VCW]   = vc_q;
        end
    endgenerate

    assign fault_any = |fault;

endmodule

// File: tb/tb_clk_period_monitor_mc.sv
// Bench for clk_period_monitor_mc: two instances (rising-edge, limit 2, four channels; both-edge, limit 1, one channel).
// Channels 0..3 map to u_dut0, channel 4 maps to u_dut1. Monitored clocks toggle on clk_ref falling edges.
// Expected results come from an interval-level model and are matched against period_vld pulses.
module tb_clk_period_monitor_mc;

    localparam int NC  = 5;
    localparam int CW  = 16;
    localparam int VCW = 8;

    typedef struct {
        int per;
        int viol;
        int fault;
        int typ;
    } exp_t;

    logic          clk_ref = 1'b0;
    logic          rst_n;
    logic [NC-1:0] lvl_v, en_v, clr_v;
    logic [CW-1:0] mn [NC];
    logic [CW-1:0] mx [NC];

    logic [4*CW-1:0]  min0, max0, plast0;
    logic [3:0]       fault0, pvld0;
    logic             fault_any0;
    logic [7:0]       ftype0;
    logic [4*VCW-1:0] viol0;
    logic [0:0]       fault1, pvld1;
    logic             fault_any1;
    logic [1:0]       ftype1;
    logic [CW-1:0]    plast1;
    logic [VCW-1:0]   viol1;

    assign min0 = {mn[3], mn[2], mn[1], mn[0]};
    assign max0 = {mx[3], mx[2], mx[1], mx[0]};

    always #5 clk_ref = ~clk_ref;

    clk_period_monitor_mc #(.NCH(4), .CW(CW), .EDGE_MODE(0), .VIOL_LIMIT(2), .VCW(VCW)) u_dut0 (
        .clk_ref(clk_ref), .rst_n(rst_n), .clk_mon(lvl_v[3:0]), .ch_en(en_v[3:0]),
        .min_period(min0), .max_period(max0), .clear(clr_v[3:0]),
        .fault(fault0), .fault_any(fault_any0), .fault_type(ftype0),
        .period_last(plast0), .period_vld(pvld0), .viol_cnt(viol0));

    clk_period_monitor_mc #(.NCH(1), .CW(CW), .EDGE_MODE(1), .VIOL_LIMIT(1), .VCW(VCW)) u_dut1 (
        .clk_ref(clk_ref), .rst_n(rst_n), .clk_mon(lvl_v[4:4]), .ch_en(en_v[4:4]),
        .min_period(mn[4]), .max_period(mx[4]), .clear(clr_v[4:4]),
        .fault(fault1), .fault_any(fault_any1), .fault_type(ftype1),
        .period_last(plast1), .period_vld(pvld1), .viol_cnt(viol1));

    int total = 0;
    int bad   = 0;

    // Reference model state: time since last edge, status counters, generator.
    int since_m [NC], first_m [NC], stall_m [NC];
    int mviol [NC], mcon [NC], mfault [NC], mtype [NC];
    int gen_on [NC], stop_req [NC], rem [NC], nlo [NC], per [NC];
    int clr_req [NC], clr_cnt [NC], clr_now [NC];
    int   ovq [NC][$];
    exp_t q [NC][$];

    function automatic int emode_of(int c); return (c == 4) ? 1 : 0; endfunction
    function automatic int lim_of(int c);   return (c == 4) ? 1 : 2; endfunction

    function automatic int o_vld(int c);   return (c < 4) ? int'(pvld0[c]) : int'(pvld1[0]); endfunction
    function automatic int o_fault(int c); return (c < 4) ? int'(fault0[c]) : int'(fault1[0]); endfunction
    function automatic int o_per(int c);   return (c < 4) ? int'(plast0[c*CW +: CW]) : int'(plast1); endfunction
    function automatic int o_viol(int c);  return (c < 4) ? int'(viol0[c*VCW +: VCW]) : int'(viol1); endfunction
    function automatic int o_type(int c);  return (c < 4) ? int'(ftype0[c*2 +: 2]) : int'(ftype1); endfunction

    function automatic void chk(string name, int c, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s ch%0d: got %0d want %0d (t=%0t)", name, c, act, exp, $time);
        end
    endfunction

    function automatic void m_clear(int c);
        mviol[c] = 0; mcon[c] = 0; mfault[c] = 0; mtype[c] = 0;
    endfunction

    // A violation bumps both counters; the fault (and its type, if not yet
    // faulted) is raised once the consecutive count reaches the limit.
    function automatic void m_viol(int c, int t);
        if (mviol[c] < 255) mviol[c]++;
        if (mcon[c] < lim_of(c)) mcon[c]++;
        if (mcon[c] == lim_of(c)) begin
            if (mfault[c] == 0) mtype[c] = t;
            mfault[c] = 1;
        end
    endfunction

    task automatic advance(int c);
        int d, t;
        bit tog, edg;
        exp_t e;
        clr_v[c] = 1'b0;
        if (clr_cnt[c] > 0) begin
            clr_cnt[c]--;
            if (clr_cnt[c] == 0) clr_v[c] = 1'b1;
        end
        if (clr_now[c] != 0) begin
            clr_v[c] = 1'b1;
            m_clear(c);
            clr_now[c] = 0;
        end
        tog = 1'b0;
        if (gen_on[c] != 0) begin
            rem[c]--;
            if (rem[c] == 0) begin
                tog = 1'b1;
                lvl_v[c] = ~lvl_v[c];
                if (lvl_v[c]) begin
                    d = (ovq[c].size() > 0) ? ovq[c].pop_front() : per[c];
                    rem[c] = d / 2;
                    nlo[c] = d - d / 2;
                end else if (stop_req[c] != 0) begin
                    gen_on[c] = 0;
                    stop_req[c] = 0;
                end else begin
                    rem[c] = nlo[c];
                end
            end
        end
        edg = tog && (emode_of(c) == 1 || lvl_v[c] == 1'b1);
        if (en_v[c]) begin
            since_m[c]++;
            if (edg) begin
                if (first_m[c] == 0 && stall_m[c] == 0) begin
                    t = (since_m[c] > int'(mx[c])) ? 2 : (since_m[c] < int'(mn[c])) ? 1 : 0;
                    if (t != 0 && clr_req[c] != 0) begin
                        // DUT clear lands on the cycle this edge is judged
                        m_clear(c);
                        clr_cnt[c] = 2;
                        clr_req[c] = 0;
                    end
                    if (t != 0) m_viol(c, t);
                    else mcon[c] = 0;
                    e.per = since_m[c]; e.viol = mviol[c]; e.fault = mfault[c]; e.typ = mtype[c];
                    q[c].push_back(e);
                end
                first_m[c] = 0;
                stall_m[c] = 0;
                since_m[c] = 0;
            end else if (stall_m[c] == 0 && since_m[c] > int'(mx[c])) begin
                stall_m[c] = 1;
                m_viol(c, 3);
            end
        end
    endtask

    task automatic step(int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_ref);
            for (int c = 0; c < NC; c++) advance(c);
        end
    endtask

    task automatic enable_ch(int c);
        en_v[c] = 1'b1; since_m[c] = 0; first_m[c] = 1; stall_m[c] = 0;
    endtask

    task automatic start_gen(int c, int p);
        per[c] = p; gen_on[c] = 1; stop_req[c] = 0; rem[c] = 2;
    endtask

    task automatic chk_status(int c);
        chk("viol_cnt", c, o_viol(c), mviol[c]);
        chk("fault", c, o_fault(c), mfault[c]);
        chk("fault_type", c, o_type(c), mtype[c]);
    endtask

    task automatic chk_fault_any();
        chk("fault_any", 0, int'(fault_any0), mfault[0] | mfault[1] | mfault[2] | mfault[3]);
    endtask

    task automatic chk_reset();
        chk("rst_fault0", 0, int'(fault0), 0);
        chk("rst_fault_any0", 0, int'(fault_any0), 0);
        chk("rst_type0", 0, int'(ftype0), 0);
        chk("rst_plast0", 0, int'(plast0 != '0), 0);
        chk("rst_pvld0", 0, int'(pvld0), 0);
        chk("rst_viol0", 0, int'(viol0 != '0), 0);
        chk("rst_fault1", 4, int'(fault1), 0);
        chk("rst_fault_any1", 4, int'(fault_any1), 0);
        chk("rst_type1", 4, int'(ftype1), 0);
        chk("rst_plast1", 4, int'(plast1), 0);
        chk("rst_pvld1", 4, int'(pvld1), 0);
        chk("rst_viol1", 4, int'(viol1), 0);
    endtask

    // Monitor: every period_vld pulse must match the oldest expected entry.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_ref);
            #1;
            if (rst_n) begin
                for (int c = 0; c < NC; c++) begin
                    if (o_vld(c) != 0) begin
                        if (q[c].size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_vld ch%0d: got period %0d want no pulse", c, o_per(c));
                        end else begin
                            e = q[c].pop_front();
                            chk("period_last", c, o_per(c), e.per);
                            chk("vld_viol_cnt", c, o_viol(c), e.viol);
                            chk("vld_fault", c, o_fault(c), e.fault);
                            chk("vld_fault_type", c, o_type(c), e.typ);
                        end
                    end
                end
            end
        end
    end

    initial begin : main
        rst_n = 1'b0;
        lvl_v = '0;
        en_v  = '0;
        clr_v = '0;
        for (int c = 0; c < NC; c++) begin
            mn[c] = 16'd10;
            mx[c] = 16'd30;
        end
        step(3);
        @(posedge clk_ref);
        #1;
        chk_reset();
        @(negedge clk_ref);
        rst_n = 1'b1;
        step(2);

        // Good clocks on ch0 and ch4, ch1 gets fast glitches.
        enable_ch(0); enable_ch(1); enable_ch(4);
        start_gen(0, 20); start_gen(1, 20); start_gen(4, 40);
        step(100);
        ovq[1].push_back(5);  ovq[1].push_back(20); ovq[1].push_back(20);
        ovq[1].push_back(5);  ovq[1].push_back(5);
        step(200);

        // Stall on ch0, then restart: first edge unchecked, next one good.
        stop_req[0] = 1;
        step(80);
        chk_status(0);
        start_gen(0, 20);
        step(100);

        // ch4 (limit 1, both edges): violations, then clear coinciding with one.
        ovq[4].push_back(10);
        step(120);
        clr_req[4] = 1;
        ovq[4].push_back(10);
        step(120);
        stop_req[4] = 1;
        step(80);
        chk_status(4);
        clr_now[4] = 1;
        step(6);
        chk_status(4);

        // Drop ch1 enable after it faulted: status held, edges ignored.
        stop_req[1] = 1;
        step(80);
        en_v[1] = 1'b0;
        step(5);
        chk_status(1);
        chk_status(0);
        chk_fault_any();
        start_gen(1, 8);
        step(60);
        chk_status(1);
        stop_req[1] = 1;
        step(20);

        // Randomized windows and periods on ch0..ch3.
        stop_req[0] = 1;
        step(80);
        for (int c = 0; c < 4; c++) clr_now[c] = 1;
        step(4);
        for (int c = 0; c < 4; c++) begin
            mn[c] = 16'($urandom_range(4, 40));
            mx[c] = 16'($urandom_range(12, 50));
        end
        enable_ch(1); enable_ch(2); enable_ch(3);
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 25; k++) ovq[c].push_back(int'($urandom_range(4, 70)));
            start_gen(c, int'($urandom_range(4, 70)));
        end
        step(1500);
        for (int c = 0; c < 4; c++) stop_req[c] = 1;
        step(120);
        for (int c = 0; c < 4; c++) chk_status(c);
        chk_fault_any();
        for (int c = 0; c < NC; c++) chk("pending_expect", c, q[c].size(), 0);

        // Reset mid-interval.
        start_gen(0, 20);
        step(37);
        rst_n = 1'b0;
        for (int c = 0; c < NC; c++) q[c].delete();
        @(posedge clk_ref);
        #1;
        chk_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_period_monitor_mc.md
# clk_period_monitor_mc

Multi-channel clock period/glitch monitor. Measures the edge-to-edge interval of NCH asynchronous monitored clocks in units of a stable reference clock, and checks each interval against a per-channel run-time-programmable [min, max] window. Violations are debounced into sticky, typed faults. Sits in the clock-safety subsystem next to the clock muxes; its outputs feed the fault aggregator and the status register bank.

## Interface
- NCH, 4: number of monitored channels (1..32)
- CW, 16: period counter / window width
- EDGE_MODE, 0: 0 = rising edges only, 1 = both edges
- VIOL_LIMIT, 2: consecutive violations needed to raise fault (1..15)
- VCW, 8: width of per-channel violation counters
- clk_ref  in  1  reference clock, all logic in this domain
- rst_n  in  1  reset rst_n, asynchronous, active-low
- clk_mon  in  NCH  monitored clocks, async to clk_ref
- ch_en  in  NCH  per-channel enable
- min_period  in  NCH*CW  per-channel minimum interval, channel i at [i*CW +: CW]
- max_period  in  NCH*CW  per-channel maximum interval, same packing
- clear  in  NCH  per-channel pulse: clear fault, type, consecutive and violation counters
- fault  out  NCH  sticky per-channel fault
- fault_any  out  1  OR of fault
- fault_type  out  2*NCH  type latched when fault rose: 00 none, 01 fast, 10 slow, 11 stall
- period_last  out  NCH*CW  last measured interval
- period_vld  out  NCH  1-cycle pulse when period_last updates
- viol_cnt  out  NCH*VCW  total violations since clear, saturating

## Operation
- Per channel: 2-flop synchronizer plus 1 history flop. Edge = rise of synced value (EDGE_MODE 0) or any change (EDGE_MODE 1).
- cnt (CW bits) increments every cycle and saturates at all-ones. On an edge cycle, cnt is loaded with 1. Interval d = cnt value sampled on the edge cycle = clk_ref cycles since the previous edge.
- States per channel:
  - IDLE: ch_en=0. cnt held at 0; no checks. fault, fault_type and viol_cnt hold their values.
  - ARM: entered on ch_en rising. Waits for the first edge; that edge goes to RUN without a period check.
  - RUN: on each edge, period_last<=d and period_vld=1. d<min → fast violation; d>max → slow violation; otherwise good.
  - STALL: entered from ARM or RUN on the cycle cnt first exceeds max (stall violation, counted once). Stays until the next edge, which goes to RUN with no check and no period_vld.
- ch_en low in any state → IDLE next cycle.
- Violation: viol_cnt += 1 (saturating); consec += 1 (saturates at VIOL_LIMIT). A good interval sets consec to 0.
- When consec reaches VIOL_LIMIT: fault<=1, and fault_type<=type of that violation if fault was 0. Later violations do not change fault_type.
- Window compares are unsigned. Window inputs are sampled live; a change mid-interval applies at the next check. min>max: every edge violates (slow takes precedence in type).
- Simultaneous clear and violation on the same channel: the clear is applied first, then that cycle's violation is counted. Result is viol_cnt=1, consec=1; with VIOL_LIMIT=1, fault=1.

## Timing
- Reset: fault=0, fault_any=0, fault_type=0, period_last=0, period_vld=0, viol_cnt=0, all channels in IDLE, sync flops 0.
- Detection latency: clk_mon transition to internal edge = 2–3 clk_ref cycles.
- Edge cycle → period_vld, period_last, viol_cnt and fault registered 1 cycle later.
- Stall raised 1 cycle after cnt = max+1.
- fault_any is combinational OR of the fault registers.
- Monitored clock requirement: high and low phases each ≥ 2 clk_ref cycles. Narrower pulses may be lost; a lost pulse shows up as a slow or stall violation.

## Test plan
- Ch0 toggles with period 20 clk_ref, min=10, max=30 → period_vld every 20 cycles, period_last=20, fault=0, viol_cnt=0.
- VIOL_LIMIT=2, one interval of 5 then period 20 → viol_cnt=1, fault=0. Two consecutive intervals of 5 → fault=1, fault_type=01.
- Clock stops with max=30 → STALL entered at cnt=31, viol_cnt+1 exactly once. On restart, the first edge is unchecked and the next interval of 20 is good.
- EDGE_MODE=1 with 50% duty cycle, period 40 → period_last=20 per edge.
- Clear asserted in the same cycle as a violation, VIOL_LIMIT=1 → viol_cnt=1, fault=1. Clear alone → all channel status returns to 0.
- Independent channels: ch1 glitches while ch0 is good → only fault[1] and fault_any set. Drop ch_en[1] → ch1 in IDLE with fault held. Assert rst_n mid-interval → all outputs return to reset values.
